ext_bus_ctrl: RTL and testbench

Parametrised external memory bus controller for the user-project core. Converts single 32-bit internal requests into multiplexed address/data cycles on the GPIO pad bus: address latch phases (le_hi/le_lo), then read/write data beats with active-low strobes. Supports 16- or 32-bit external bus, a per-request programmable wait count, per-byte write strobes and a cached-upper-address optimisation that skips the le_hi phase.

---
 rtl/ext_bus_pkg.sv | 25 ++
 rtl/ext_bus_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_ext_bus_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_bus_pkg.sv
// Shared types and helpers for the external memory bus controller.
package ext_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAT_HI,
        LAT_LO,
        TURN,
        ACCESS,
        RECOVER
    } state_t;

    // Number of external data beats needed to move one 32-bit word.
    function automatic int unsigned beats(input int unsigned bus_w);
        return 32 / bus_w;
    endfunction

    // Right-aligns lane idx (lane_w bits wide) of data; caller truncates.
    function automatic logic [31:0] lane_sel(input logic [31:0] data,
                                             input int unsigned idx,
                                             input int unsigned lane_w);
        return data >> (idx * lane_w);
    endfunction

endpackage

// File: rtl/ext_bus_ctrl.sv
// External memory bus controller: one 32-bit request becomes latched
// address phases followed by strobed data beats on a multiplexed pad bus.
module ext_bus_ctrl
    import ext_bus_pkg::*;
#(
    parameter int unsigned BUS_W  = 16,
    parameter int unsigned WAIT_W = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    input  logic [3:0]          req_be,
    input  logic [WAIT_W-1:0]   wait_cfg,
    output logic                rsp_valid,
    output logic [31:0]         rsp_rdata,
    input  logic [BUS_W-1:0]    bus_in,
    output logic [BUS_W-1:0]    bus_out,
    output logic                bus_oe,
    output logic                bus_dir,
    output logic                le_lo,
    output logic                le_hi,
    output logic                oeb,
    output logic [BUS_W/8-1:0]  web
);

    localparam int unsigned BEATS  = beats(BUS_W);
    localparam int unsigned BE_W   = BUS_W / 8;
    localparam int unsigned SHIFT  = $clog2(BE_W);
    localparam int unsigned BEAT_W = 2;
    localparam logic [BEAT_W-1:0] NONE = BEAT_W'(BEATS);

    state_t             state;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic               we_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [WAIT_W-1:0]  cnt;
    logic [BEAT_W-1:0]  beat;
    logic [15:0]        hi_cache;
    logic               hi_valid;
    logic [31:0]        rbuf;

    logic [31:0]        acc_waddr_c;
    logic [31:0]        lat_waddr_c;
    logic [31:0]        cur_waddr_c;
    logic [BEAT_W-1:0]  acc_first_c;
    logic [BEAT_W-1:0]  nxt_beat_c;
    logic               enter_lat_c;
    logic               lat_hi_c;

    // First beat at or after start that needs a bus cycle; NONE if none left.
    function automatic logic [BEAT_W-1:0] first_beat(input logic [3:0]        be,
                                                     input logic              we,
                                                     input logic [BEAT_W-1:0] start);
        logic [BEAT_W-1:0] r;
        logic              found;
        r     = NONE;
        found = 1'b0;
        for (int unsigned k = 0; k < BEATS; k++) begin
            if (!found && BEAT_W'(k) >= start &&
                (!we || BE_W'(lane_sel(32'(be), k, BE_W)) != '0)) begin
                r     = BEAT_W'(k);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Beat selection and address-latch decision for acceptance and beat advance.
    always_comb begin
        acc_waddr_c = req_addr >> SHIFT;
        acc_first_c = first_beat(req_be, req_we, '0);
        nxt_beat_c  = first_beat(be_q, we_q, beat + BEAT_W'(1));
        cur_waddr_c = addr_q + 32'(beat);
        if (state == IDLE) begin
            lat_waddr_c = acc_waddr_c + 32'(acc_first_c);
            enter_lat_c = req_valid && (acc_first_c != NONE);
        end else begin
            lat_waddr_c = addr_q + 32'(nxt_beat_c);
            enter_lat_c = (state == RECOVER) && (nxt_beat_c != NONE);
        end
        lat_hi_c = (BUS_W == 16) && (!hi_valid || lat_waddr_c[31:16] != hi_cache);
    end

    // Bus sequencer with registered pad and handshake outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            bus_out   <= '0;
            bus_oe    <= 1'b0;
            bus_dir   <= 1'b0;
            le_lo     <= 1'b0;
            le_hi     <= 1'b0;
            oeb       <= 1'b1;
            web       <= '1;
            hi_valid  <= 1'b0;
            hi_cache  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            wait_q    <= '0;
            cnt       <= '0;
            beat      <= '0;
            rbuf      <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        addr_q    <= acc_waddr_c;
                        wdata_q   <= req_wdata;
                        be_q      <= req_be;
                        we_q      <= req_we;
                        wait_q    <= wait_cfg;
                        if (acc_first_c == NONE) begin
                            // Fully masked write: no bus activity, just complete.
                            state <= RECOVER;
                            beat  <= BEAT_W'(BEATS - 1);
                        end else begin
                            beat  <= acc_first_c;
                        end
                    end
                end
                LAT_HI: begin
                    state   <= LAT_LO;
                    le_hi   <= 1'b0;
                    le_lo   <= 1'b1;
                    bus_out <= BUS_W'(cur_waddr_c);
                end
                LAT_LO: begin
                    le_lo <= 1'b0;
                    le_hi <= 1'b0;
                    cnt   <= wait_q;
                    if (we_q) begin
                        state   <= ACCESS;
                        bus_out <= BUS_W'(lane_sel(wdata_q, beat, BUS_W));
                        web     <= ~BE_W'(lane_sel(32'(be_q), beat, BE_W));
                    end else begin
                        state   <= TURN;
                        bus_oe  <= 1'b0;
                        bus_dir <= 1'b1;
                    end
                end
                TURN: begin
                    state <= ACCESS;
                    oeb   <= 1'b0;
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state <= RECOVER;
                        oeb   <= 1'b1;
                        web   <= '1;
                        if (!we_q) begin
                            for (int unsigned k = 0; k < BEATS; k++) begin
                                if (beat == BEAT_W'(k)) begin
                                    rbuf[k*BUS_W +: BUS_W] <= bus_in;
                                end
                            end
                        end
                    end else begin
                        cnt <= cnt - WAIT_W'(1);
                    end
                end
                RECOVER: begin
                    if (nxt_beat_c == NONE) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        bus_oe    <= 1'b0;
                        bus_dir   <= 1'b0;
                        bus_out   <= '0;
                        if (!we_q) begin
                            rsp_rdata <= rbuf;
                        end
                    end else begin
                        beat <= nxt_beat_c;
                    end
                end
                default: state <= IDLE;
            endcase

            // Address phase entry, shared by acceptance and beat advance.
            if (enter_lat_c) begin
                bus_oe  <= 1'b1;
                bus_dir <= 1'b0;
                if (lat_hi_c) begin
                    state    <= LAT_HI;
                    le_hi    <= 1'b1;
                    bus_out  <= BUS_W'(lat_waddr_c[31:16]);
                    hi_cache <= lat_waddr_c[31:16];
                    hi_valid <= 1'b1;
                end else begin
                    state   <= LAT_LO;
                    le_lo   <= 1'b1;
                    le_hi   <= (BUS_W == 32);
                    bus_out <= BUS_W'(lat_waddr_c);
                end
            end
        end
    end

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Directed bench for ext_bus_ctrl (16-bit bus) with an external memory model.
module tb_ext_bus_ctrl;

    localparam int unsigned BUS_W  = 16;
    localparam int unsigned WAIT_W = 4;

    logic               clk;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [31:0]        req_addr;
    logic [31:0]        req_wdata;
    logic [3:0]         req_be;
    logic [WAIT_W-1:0]  wait_cfg;
    logic               rsp_valid;
    logic [31:0]        rsp_rdata;
    logic [BUS_W-1:0]   bus_in;
    logic [BUS_W-1:0]   bus_out;
    logic               bus_oe;
    logic               bus_dir;
    logic               le_lo;
    logic               le_hi;
    logic               oeb;
    logic [1:0]         web;

    ext_bus_ctrl #(.BUS_W(BUS_W), .WAIT_W(WAIT_W)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .wait_cfg  (wait_cfg),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .bus_dir   (bus_dir),
        .le_lo     (le_lo),
        .le_hi     (le_hi),
        .oeb       (oeb),
        .web       (web)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] rdata;
        int          lat;
    } exp_t;
    exp_t sb[$];

    // External device model
    logic [15:0] mem [int unsigned];
    logic [15:0] hi_lat = '0;
    logic [15:0] lo_lat = '0;
    logic [15:0] rd_q   = '0;

    function automatic logic [15:0] mem_rd(input int unsigned a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    assign bus_in = oeb ? '0 : rd_q;

    // Monitors
    int          le_hi_cnt  = 0;
    logic [15:0] last_hi    = '0;
    int          web_cyc    = 0;
    logic [1:0]  last_web   = 2'b11;
    int          oeb_run    = 0;
    int          oeb_runs[$];
    int          viol       = 0;
    logic [31:0] prev_rdata = '0;

    always @(negedge clk) begin
        if (le_hi) begin
            hi_lat = bus_out;
            last_hi = bus_out;
            le_hi_cnt++;
        end
        if (le_lo) lo_lat = bus_out;
        rd_q = mem_rd({hi_lat, lo_lat});
        if (web != 2'b11) begin
            web_cyc++;
            last_web = web;
        end
        if (!oeb) oeb_run++;
        else if (oeb_run > 0) begin
            oeb_runs.push_back(oeb_run);
            oeb_run = 0;
        end
        if ((!oeb && web != 2'b11) || (bus_oe && bus_dir) ||
            ((le_lo || le_hi) && (!oeb || web != 2'b11))) viol++;
        if (!rst && !rsp_valid && rsp_rdata !== prev_rdata) viol++;
        prev_rdata = rsp_rdata;
    end

    always @(posedge clk) begin
        logic [15:0] w;
        if (web != 2'b11) begin
            w = mem_rd({hi_lat, lo_lat});
            if (!web[0]) w[7:0]  = bus_out[7:0];
            if (!web[1]) w[15:8] = bus_out[15:8];
            mem[{hi_lat, lo_lat}] = w;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input logic [WAIT_W-1:0] w);
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        wait_cfg  = w;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        exp_t e;
        int   lat;
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, 32'(lat), 32'(e.lat));
        if (!e.we) check({tag, "_rdata"}, rsp_rdata, e.rdata);
        @(negedge clk);
        check({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [WAIT_W-1:0] w, input logic [31:0] exp_rdata, input int exp_lat);
        exp_t e;
        e.we = we;
        e.rdata = exp_rdata;
        e.lat = exp_lat;
        sb.push_back(e);
        send_req(we, addr, wdata, be, w);
        wait_rsp(tag);
    endtask

    initial begin
        int   le0;
        int   wc0;
        int   n;
        logic seen;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        wait_cfg  = '0;
        mem[32'h0020_0004] = 16'h5678;
        mem[32'h0020_0005] = 16'h1234;
        mem[32'h0020_0006] = 16'h9ABC;
        mem[32'h0020_0007] = 16'hDEF0;
        mem[32'h0001_0000] = 16'h1111;
        mem[32'h0001_0001] = 16'h2222;
        mem[32'h0000_0080] = 16'h7777;
        mem[32'h0000_0081] = 16'h3344;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_bus_oe",    32'(bus_oe), 32'd0);
        check("rst_oeb",       32'(oeb), 32'd1);
        check("rst_web",       32'(web), 32'h3);
        check("rst_le",        32'({le_hi, le_lo, bus_dir}), 32'd0);

        // Cold read: le_hi with upper word, two beats
        le0 = le_hi_cnt;
        do_req("cold_read", 1'b0, 32'h0040_0008, '0, 4'hF, 4'd0, 32'h1234_5678, 9);
        check("cold_le_hi_cnt", 32'(le_hi_cnt - le0), 32'd1);
        check("cold_le_hi_val", 32'(last_hi), 32'h0020);

        // Hi-cache hit: no le_hi, one cycle shorter
        le0 = le_hi_cnt;
        do_req("hit_read", 1'b0, 32'h0040_000C, '0, 4'hF, 4'd0, 32'hDEF0_9ABC, 8);
        check("hit_le_hi_cnt", 32'(le_hi_cnt - le0), 32'd0);

        // Write at the top of a 64K page, then cross to the next page
        le0 = le_hi_cnt;
        do_req("page_end_wr", 1'b1, 32'h0001_FFFC, 32'hAABB_CCDD, 4'hF, 4'd0, '0, 7);
        check("page_end_le_hi_cnt", 32'(le_hi_cnt - le0), 32'd1);
        check("mem_fffe", 32'(mem_rd(32'h0000_FFFE)), 32'h0000_CCDD);
        check("mem_ffff", 32'(mem_rd(32'h0000_FFFF)), 32'h0000_AABB);
        le0 = le_hi_cnt;
        do_req("next_page_rd", 1'b0, 32'h0002_0000, '0, 4'hF, 4'd0, 32'h2222_1111, 9);
        check("next_page_le_hi_cnt", 32'(le_hi_cnt - le0), 32'd1);
        check("next_page_le_hi_val", 32'(last_hi), 32'h0001);

        // Write whose second beat wraps the low address: re-latch mid-request
        le0 = le_hi_cnt;
        do_req("wrap_wr", 1'b1, 32'h0001_FFFE, 32'h5566_7788, 4'hF, 4'd0, '0, 8);
        check("wrap_le_hi_cnt", 32'(le_hi_cnt - le0), 32'd2);
        check("wrap_mem_lo", 32'(mem_rd(32'h0000_FFFF)), 32'h0000_7788);
        check("wrap_mem_hi", 32'(mem_rd(32'h0001_0000)), 32'h0000_5566);

        // Partial byte enables: only beat 1, one byte lane
        wc0 = web_cyc;
        do_req("be0100_wr", 1'b1, 32'h0000_0100, 32'h00EE_0000, 4'b0100, 4'd0, '0, 4);
        check("be0100_web", 32'(last_web), 32'h2);
        check("be0100_web_cyc", 32'(web_cyc - wc0), 32'd1);
        check("be0100_mem81", 32'(mem_rd(32'h0000_0081)), 32'h0000_33EE);
        check("be0100_mem80", 32'(mem_rd(32'h0000_0080)), 32'h0000_7777);

        // No byte enables: immediate completion, no bus activity
        wc0 = web_cyc;
        le0 = le_hi_cnt;
        do_req("be0_wr", 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'b0000, 4'd0, '0, 1);
        check("be0_web_cyc", 32'(web_cyc - wc0), 32'd0);
        check("be0_le_hi_cnt", 32'(le_hi_cnt - le0), 32'd0);

        // Wait states: oeb low for wait_cfg+1 cycles per beat
        oeb_runs.delete();
        do_req("wait3_rd", 1'b0, 32'h0000_0100, '0, 4'hF, 4'd3, 32'h33EE_7777, 14);
        check("wait3_runs", 32'(oeb_runs.size()), 32'd2);
        for (int i = 0; i < oeb_runs.size(); i++) check("wait3_oeb_run", 32'(oeb_runs[i]), 32'd4);

        // Asynchronous reset during a write ACCESS
        send_req(1'b1, 32'h0000_0100, 32'h33EE_7777, 4'hF, 4'd5);
        n = 0;
        @(negedge clk);
        while (web == 2'b11 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reached_access", 32'(web != 2'b11), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_web", 32'(web), 32'h3);
        check("rst_mid_bus_oe", 32'(bus_oe), 32'd0);
        check("rst_mid_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("rst_mid_no_rsp", 32'(seen), 32'd0);
        le0 = le_hi_cnt;
        do_req("post_rst_rd", 1'b0, 32'h0000_0100, '0, 4'hF, 4'd0, 32'h33EE_7777, 9);
        check("post_rst_le_hi_cnt", 32'(le_hi_cnt - le0), 32'd1);

        check("bus_invariants", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
